// File: rtl/chunked_first_one_finder.sv
// chunked_first_one_finder
//
// Multi-cycle first-one finder for the FPU front end. An accepted operand is
// scanned CHUNK bits per cycle, starting from the top chunk when looking for
// the highest set bit (mode 0, normalisation) or from the bottom chunk when
// looking for the lowest set bit (mode 1, sticky / trailing-zero use). The
// scan stops at the first chunk that contains a set bit.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, aborts any operation in flight
//   in_valid   operand offered by the source
//   in_ready   high only while idle; operand and mode are taken when both high
//   number     SIZE-bit operand
//   mode       0 = highest set bit, 1 = lowest set bit
//   out_valid  result available, held until out_ready
//   out_ready  consumer takes the result
//   max_power  one-hot mask of the found bit, all zero for a zero operand
//   index      binary position of the found bit, 0 for a zero operand
//   zero       operand had no set bit

module chunked_first_one_finder #(
  parameter  int SIZE   = 31,
  parameter  int CHUNK  = 4,
  localparam int IDX_W  = $clog2(SIZE),
  localparam int NCHUNK = (SIZE + CHUNK - 1) / CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  number,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  max_power,
  output logic [IDX_W-1:0] index,
  output logic             zero
);

  localparam int PTR_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SIZE-1:0]  operand_q, operand_d;
  logic             mode_q, mode_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [SIZE-1:0]  max_power_q, max_power_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] chunk_bits;
  logic             chunk_hit;
  logic             last_chunk;
  int               hit_pos;
  logic [IDX_W-1:0] hit_index;

  // Gather the chunk currently pointed at. Bit positions at or above SIZE do
  // not exist in the operand, so the top chunk is zero-padded and those
  // positions can never be reported.
  always_comb begin
    chunk_bits = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      for (int j = 0; j < CHUNK; j++) begin
        if ((c * CHUNK + j) < SIZE && ptr_q == PTR_W'(c)) begin
          chunk_bits[j] = operand_q[c * CHUNK + j];
        end
      end
    end
  end

  // Priority pick inside the chunk: the last matching bit in the loop wins,
  // so ascending order yields the highest set bit and descending the lowest.
  always_comb begin
    hit_pos = 0;
    if (!mode_q) begin
      for (int j = 0; j < CHUNK; j++) begin
        if (chunk_bits[j]) hit_pos = j;
      end
    end else begin
      for (int j = CHUNK - 1; j >= 0; j--) begin
        if (chunk_bits[j]) hit_pos = j;
      end
    end
  end

  assign chunk_hit  = |chunk_bits;
  assign hit_index  = IDX_W'(int'(ptr_q) * CHUNK + hit_pos);
  // The last chunk to examine depends on scan direction.
  assign last_chunk = mode_q ? (ptr_q == PTR_W'(NCHUNK - 1)) : (ptr_q == '0);

  // Next-state logic. Results are only written when the scan finishes, so
  // they stay frozen through DONE regardless of how long the consumer stalls.
  always_comb begin
    state_d     = state_q;
    operand_d   = operand_q;
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    max_power_d = max_power_q;
    index_d     = index_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          operand_d = number;
          mode_d    = mode;
          ptr_d     = mode ? '0 : PTR_W'(NCHUNK - 1);
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (chunk_hit) begin
          index_d     = hit_index;
          max_power_d = {{(SIZE-1){1'b0}}, 1'b1} << hit_index;
          zero_d      = 1'b0;
          state_d     = DONE;
        end else if (last_chunk) begin
          index_d     = '0;
          max_power_d = '0;
          zero_d      = 1'b1;
          state_d     = DONE;
        end else begin
          ptr_d = mode_q ? (ptr_q + PTR_W'(1)) : (ptr_q - PTR_W'(1));
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      operand_q   <= '0;
      mode_q      <= 1'b0;
      ptr_q       <= '0;
      max_power_q <= '0;
      index_q     <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      max_power_q <= max_power_d;
      index_q     <= index_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign max_power = max_power_q;
  assign index     = index_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_first_one_finder.sv
// Testbench for chunked_first_one_finder. Three builds are instantiated
// (31/4, 8/8 and 31/1); a selector routes the handshake to one of them at a
// time and muxes its outputs back for checking against a bit-loop model.

module tb_chunked_first_one_finder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        mode;
  logic [30:0] number;
  int          sel;

  // Build A: SIZE=31, CHUNK=4
  logic        in_ready_a, out_valid_a, zero_a;
  logic [30:0] max_power_a;
  logic [4:0]  index_a;
  // Build B: SIZE=8, CHUNK=8
  logic        in_ready_b, out_valid_b, zero_b;
  logic [7:0]  max_power_b;
  logic [2:0]  index_b;
  // Build C: SIZE=31, CHUNK=1
  logic        in_ready_c, out_valid_c, zero_c;
  logic [30:0] max_power_c;
  logic [4:0]  index_c;

  logic        m_in_ready, m_out_valid, m_zero;
  logic [31:0] m_max_power, m_index;

  int checks = 0;
  int fails  = 0;

  int sizes[3]  = '{31, 8, 31};
  int chunks[3] = '{4, 8, 1};

  chunked_first_one_finder #(.SIZE(31), .CHUNK(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && sel == 0), .in_ready(in_ready_a),
    .number(number), .mode(mode),
    .out_valid(out_valid_a), .out_ready(out_ready && sel == 0),
    .max_power(max_power_a), .index(index_a), .zero(zero_a)
  );

  chunked_first_one_finder #(.SIZE(8), .CHUNK(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && sel == 1), .in_ready(in_ready_b),
    .number(number[7:0]), .mode(mode),
    .out_valid(out_valid_b), .out_ready(out_ready && sel == 1),
    .max_power(max_power_b), .index(index_b), .zero(zero_b)
  );

  chunked_first_one_finder #(.SIZE(31), .CHUNK(1)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && sel == 2), .in_ready(in_ready_c),
    .number(number), .mode(mode),
    .out_valid(out_valid_c), .out_ready(out_ready && sel == 2),
    .max_power(max_power_c), .index(index_c), .zero(zero_c)
  );

  // Route the selected build's outputs to one set of checking signals.
  always_comb begin
    m_in_ready  = in_ready_a;
    m_out_valid = out_valid_a;
    m_zero      = zero_a;
    m_max_power = {1'b0, max_power_a};
    m_index     = {27'd0, index_a};
    case (sel)
      1: begin
        m_in_ready  = in_ready_b;
        m_out_valid = out_valid_b;
        m_zero      = zero_b;
        m_max_power = {24'd0, max_power_b};
        m_index     = {29'd0, index_b};
      end
      2: begin
        m_in_ready  = in_ready_c;
        m_out_valid = out_valid_c;
        m_zero      = zero_c;
        m_max_power = {1'b0, max_power_c};
        m_index     = {27'd0, index_c};
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design never answers at all.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and every failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: scan every bit of the operand and keep the highest (mode 0)
  // or the first-found lowest (mode 1) set bit. Latency is the number of
  // chunks walked from the starting end to the chunk holding that bit.
  function automatic void model(input logic [31:0] num, input int size, input int chunk,
                                input bit md, output int idx, output bit zr, output int k);
    int nch;
    nch = (size + chunk - 1) / chunk;
    idx = 0;
    zr  = 1'b1;
    for (int b = 0; b < size; b++) begin
      if (num[b]) begin
        if (!md || zr) idx = b;
        zr = 1'b0;
      end
    end
    if (zr)      k = nch;
    else if (md) k = idx / chunk + 1;
    else         k = nch - idx / chunk;
  endfunction

  // One full transaction on the selected build: accept, scan, stall, drain.
  task automatic applyStimulus(input logic [31:0] num, input bit md, input int stall);
    int          exp_idx, exp_k, edges, waits;
    bit          exp_zero;
    logic [31:0] exp_mask;
    model(num, sizes[sel], chunks[sel], md, exp_idx, exp_zero, exp_k);
    exp_mask = exp_zero ? 32'd0 : (32'd1 << exp_idx);

    waits = 0;
    while (!m_in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    checkOutput("in_ready_idle", {31'd0, m_in_ready}, 32'd1);

    number   = num[30:0];
    mode     = md;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble the source after accept; the result must not follow it.
    in_valid = 1'b0;
    number   = 31'($urandom);
    mode     = 1'($urandom);
    checkOutput("in_ready_scan", {31'd0, m_in_ready}, 32'd0);

    edges = 0;
    while (!m_out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("out_valid", {31'd0, m_out_valid}, 32'd1);
    checkOutput("latency", edges, exp_k);
    checkOutput("index", m_index, exp_idx);
    checkOutput("max_power", m_max_power, exp_mask);
    checkOutput("zero", {31'd0, m_zero}, {31'd0, exp_zero});

    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checkOutput("stall_valid", {31'd0, m_out_valid}, 32'd1);
      checkOutput("stall_in_ready", {31'd0, m_in_ready}, 32'd0);
      checkOutput("stall_index", m_index, exp_idx);
      checkOutput("stall_max_power", m_max_power, exp_mask);
      checkOutput("stall_zero", {31'd0, m_zero}, {31'd0, exp_zero});
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("drain_valid", {31'd0, m_out_valid}, 32'd0);
    checkOutput("drain_in_ready", {31'd0, m_in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] num;
    int          kind;

    sel       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    number    = '0;

    // Reset held for two cycles, then released.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
    checkOutput("rst_max_power", m_max_power, 32'd0);
    checkOutput("rst_index", m_index, 32'd0);
    checkOutput("rst_zero", {31'd0, m_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", {31'd0, m_in_ready}, 32'd1);

    // Directed cases on the 31/4 build.
    $display("[TB] directed cases");
    applyStimulus(32'h4000_0000, 1'b0, 0);
    applyStimulus(32'h0000_0001, 1'b0, 0);
    applyStimulus(32'h0000_0001, 1'b1, 0);
    applyStimulus(32'h0000_0000, 1'b0, 0);
    applyStimulus(32'h0000_0000, 1'b1, 0);
    applyStimulus(32'h0001_2340, 1'b1, 0);
    applyStimulus(32'h0001_2340, 1'b0, 0);
    applyStimulus(32'h4000_0000, 1'b0, 5);

    // Reset during a long scan: nothing may come out afterwards.
    $display("[TB] reset mid-scan");
    number   = 31'h0000_0001;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_out_valid", {31'd0, m_out_valid}, 32'd0);
    checkOutput("abort_in_ready", {31'd0, m_in_ready}, 32'd1);
    checkOutput("abort_max_power", m_max_power, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_quiet", {31'd0, m_out_valid}, 32'd0);
    end

    // Reset while a result is waiting in DONE.
    applyStimulus(32'h0000_0010, 1'b1, 0);
    number   = 31'h0000_0100;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("done_before_rst", {31'd0, m_out_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("done_abort_valid", {31'd0, m_out_valid}, 32'd0);
    checkOutput("done_abort_index", m_index, 32'd0);

    // Random operands on each build, biased toward sparse and zero values.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      $display("[TB] random run on build %0d", s);
      for (int i = 0; i < ((s == 0) ? 100 : 50); i++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0:       num = $urandom;
          1:       num = 32'd1 << $urandom_range(0, 30);
          2:       num = 32'd0;
          default: num = $urandom >> $urandom_range(0, 31);
        endcase
        num[31] = 1'b0;
        applyStimulus(num, 1'($urandom), $urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
